// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine in front of the VGA peripheral: forwards CPU
// writes when idle, otherwise emits clipped X/Y/pixel write sequences.
module vga_rect_fill #(
    parameter logic [7:0] BASE_ADDR = 8'hC0,
    parameter int         X_MAX     = 160,
    parameter int         Y_MAX     = 120
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic [7:0] VGA_ADDR,
    output logic [7:0] VGA_DATA,
    output logic       VGA_WE,
    output logic       BUSY,
    output logic       DONE,
    output logic       START_ERR
);

    localparam logic [7:0] A_X0  = BASE_ADDR;
    localparam logic [7:0] A_Y0  = BASE_ADDR + 8'd1;
    localparam logic [7:0] A_W   = BASE_ADDR + 8'd2;
    localparam logic [7:0] A_H   = BASE_ADDR + 8'd3;
    localparam logic [7:0] A_COL = BASE_ADDR + 8'd4;
    localparam logic [7:0] A_CMD = BASE_ADDR + 8'd5;

    localparam logic [8:0] XM = 9'(X_MAX);
    localparam logic [8:0] YM = 9'(Y_MAX);

    localparam logic [7:0] V_X = 8'hB0;
    localparam logic [7:0] V_Y = 8'hB1;
    localparam logic [7:0] V_P = 8'hB2;

    typedef enum logic [2:0] {
        IDLE, EMIT_X, EMIT_Y, EMIT_P, GAP, FIN
    } state_t;

    typedef enum logic [1:0] {
        M_X, M_Y, M_P
    } mirror_t;

    state_t     state;
    mirror_t    mirror;

    logic [7:0] x0_r, y0_r, w_r, h_r, col_r;
    logic [7:0] lx0, lcol, cx, cy;
    logic [8:0] lxe, lye;
    logic       last, abort_pend;

    logic       cmd_wr, abort_cmd, start_cmd;
    logic [8:0] sum_x, sum_y, xe, ye;
    logic       empty;

    function automatic mirror_t mir_next(input mirror_t m,
                                         input logic [7:0] a);
        mirror_t n;
        n = m;
        unique case (1'b1)
            (m == M_X) && (a == V_X): n = M_Y;
            (m == M_Y) && (a == V_Y): n = M_P;
            (m == M_P) && (a == V_P): n = M_X;
            default:                  n = m;
        endcase
        return n;
    endfunction

    always_comb begin
        cmd_wr    = BUS_WE && (BUS_ADDR == A_CMD);
        abort_cmd = cmd_wr && BUS_DATA[1];
        start_cmd = cmd_wr && BUS_DATA[0] && !BUS_DATA[1];
        sum_x     = {1'b0, x0_r} + {1'b0, w_r};
        sum_y     = {1'b0, y0_r} + {1'b0, h_r};
        xe        = (sum_x > XM) ? XM : sum_x;
        ye        = (sum_y > YM) ? YM : sum_y;
        empty     = (xe <= {1'b0, x0_r}) || (ye <= {1'b0, y0_r});
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            x0_r  <= '0;
            y0_r  <= '0;
            w_r   <= '0;
            h_r   <= '0;
            col_r <= '0;
        end else if (BUS_WE) begin
            if (BUS_ADDR == A_X0)  x0_r  <= BUS_DATA;
            if (BUS_ADDR == A_Y0)  y0_r  <= BUS_DATA;
            if (BUS_ADDR == A_W)   w_r   <= BUS_DATA;
            if (BUS_ADDR == A_H)   h_r   <= BUS_DATA;
            if (BUS_ADDR == A_COL) col_r <= BUS_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            mirror     <= M_X;
            VGA_ADDR   <= '0;
            VGA_DATA   <= '0;
            VGA_WE     <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            START_ERR  <= 1'b0;
            lx0        <= '0;
            lcol       <= '0;
            cx         <= '0;
            cy         <= '0;
            lxe        <= '0;
            lye        <= '0;
            last       <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            VGA_WE <= 1'b0;
            DONE   <= 1'b0;
            if (abort_cmd && BUSY)
                abort_pend <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (start_cmd && mirror == M_X) begin
                        START_ERR  <= 1'b0;
                        abort_pend <= 1'b0;
                        if (empty) begin
                            DONE  <= 1'b1;
                            state <= FIN;
                        end else begin
                            lx0      <= x0_r;
                            lxe      <= xe;
                            lye      <= ye;
                            lcol     <= col_r;
                            cx       <= x0_r;
                            cy       <= y0_r;
                            last     <= 1'b0;
                            BUSY     <= 1'b1;
                            VGA_ADDR <= V_X;
                            VGA_DATA <= x0_r;
                            VGA_WE   <= 1'b1;
                            mirror   <= mir_next(mirror, V_X);
                            state    <= EMIT_X;
                        end
                    end else begin
                        if (start_cmd)
                            START_ERR <= 1'b1;
                        if (BUS_WE) begin
                            VGA_ADDR <= BUS_ADDR;
                            VGA_DATA <= BUS_DATA;
                            VGA_WE   <= 1'b1;
                            mirror   <= mir_next(mirror, BUS_ADDR);
                        end
                    end
                end
                EMIT_X: begin
                    VGA_ADDR <= V_Y;
                    VGA_DATA <= cy;
                    VGA_WE   <= 1'b1;
                    mirror   <= mir_next(mirror, V_Y);
                    state    <= EMIT_Y;
                end
                EMIT_Y: begin
                    VGA_ADDR <= V_P;
                    VGA_DATA <= lcol;
                    VGA_WE   <= 1'b1;
                    mirror   <= mir_next(mirror, V_P);
                    state    <= EMIT_P;
                end
                EMIT_P: begin
                    // Raster advance happens here so GAP only decides.
                    if ({1'b0, cx} + 9'd1 == lxe) begin
                        cx <= lx0;
                        if ({1'b0, cy} + 9'd1 == lye)
                            last <= 1'b1;
                        else
                            cy <= cy + 8'd1;
                    end else begin
                        cx <= cx + 8'd1;
                    end
                    state <= GAP;
                end
                GAP: begin
                    if (last || abort_pend || abort_cmd) begin
                        BUSY       <= 1'b0;
                        DONE       <= 1'b1;
                        abort_pend <= 1'b0;
                        state      <= FIN;
                    end else begin
                        VGA_ADDR <= V_X;
                        VGA_DATA <= cx;
                        VGA_WE   <= 1'b1;
                        mirror   <= mir_next(mirror, V_X);
                        state    <= EMIT_X;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/vga_rect_fill.md
# vga_rect_fill

Hardware rectangle-fill engine sitting directly upstream of the VGA bus peripheral. It decodes its own CPU bus registers and, on command, generates the peripheral's X (0xB0), Y (0xB1) and pixel (0xB2) write sequence for every pixel of a clipped rectangle. When idle it forwards CPU bus writes to the peripheral unchanged, so it sits between the CPU bus and the VGA peripheral.

## Interface
Parameters:
- BASE_ADDR, 8'hC0: base of the engine register block (+0 X0, +1 Y0, +2 W, +3 H, +4 COLOUR, +5 CMD).
- X_MAX, 160: exclusive horizontal clip bound.
- Y_MAX, 120: exclusive vertical clip bound.

Ports:
- CLK  in  1  system clock; everything is on posedge.
- RESET  in  1  asynchronous, active-low reset.
- BUS_ADDR  in  8  CPU bus address.
- BUS_DATA  in  8  CPU bus write data.
- BUS_WE  in  1  CPU bus write enable.
- VGA_ADDR  out  8  address to the VGA peripheral (registered).
- VGA_DATA  out  8  data to the VGA peripheral (registered).
- VGA_WE  out  1  write enable to the VGA peripheral (registered).
- BUSY  out  1  a fill is in progress.
- DONE  out  1  one-cycle pulse when a fill completes or is aborted.
- START_ERR  out  1  sticky flag: the last start was refused.

## Operation
- **Register writes.** Writes to BASE_ADDR+0..4 load the shadow registers X0, Y0, W, H and COLOUR at any time, including while busy. The running fill uses values latched at start, so these writes never affect it.
- **CMD write (BASE_ADDR+5).**
  - DATA[1]=1 is abort. Abort takes precedence over start.
  - DATA[0]=1 with DATA[1]=0 is start.
  - Start is ignored while BUSY, and START_ERR is unchanged.
  - Abort while idle has no effect.
- **Mirror of the peripheral sequence.**
  - A 2-bit mirror of the peripheral sequencer (M_X, M_Y, M_P) tracks every write forwarded to VGA_WE.
  - M_X + 0xB0 → M_Y; M_Y + 0xB1 → M_P; M_P + 0xB2 → M_X. Any other write leaves the mirror unchanged.
  - A start is accepted only when the mirror is M_X. Otherwise START_ERR←1 and no fill runs.
  - An accepted start clears START_ERR.
- **Clipping at start.**
  - xe = min(X0+W, X_MAX) and ye = min(Y0+H, Y_MAX), both computed in 9-bit arithmetic with no wrap.
  - If xe≤X0 or ye≤Y0 (this covers W=0, H=0, X0≥X_MAX and Y0≥Y_MAX), the fill is empty: DONE pulses, BUSY stays 0 and no VGA write occurs.
- **FSM** (states IDLE, EMIT_X, EMIT_Y, EMIT_P, GAP, FIN):
  - IDLE → EMIT_X on an accepted non-empty start; cx←X0, cy←Y0.
  - IDLE → FIN on an accepted empty start.
  - EMIT_X drives (0xB0, cx, WE=1), then → EMIT_Y.
  - EMIT_Y drives (0xB1, cy, WE=1), then → EMIT_P.
  - EMIT_P drives (0xB2, COLOUR, WE=1), then → GAP.
  - GAP drives WE=0. Raster order: cx increments; when cx+1=xe, cx←X0 and cy increments.
  - GAP → FIN when the last pixel is done or an abort is pending; otherwise GAP → EMIT_X.
  - FIN: DONE=1 for one cycle, BUSY=0, then → IDLE.
- **Abort while busy.** Abort is latched as pending. The current pixel always completes through EMIT_P and GAP, so the peripheral is left in M_X.
- **Pass-through.**
  - In IDLE, each CPU write (all addresses, including engine registers) is forwarded one cycle later on VGA_ADDR/VGA_DATA/VGA_WE.
  - While BUSY, CPU writes are not forwarded and are dropped.
  - In FIN, CPU writes are not forwarded either.
- **Reset.** All outputs 0, FSM IDLE, mirror M_X, shadow registers 0, pending abort cleared. Reset mid-fill abandons the fill with no DONE. The VGA peripheral shares the system reset at top level.

## Timing
- Let cycle t be the edge that samples the start write.
  - BUSY=1 and the first VGA_WE (0xB0) are visible from t+1.
  - Each pixel takes 4 cycles: X, Y, P, gap.
  - For N pixels, BUSY is high for cycles t+1..t+4N, and DONE is high in cycle t+4N+1.
- Empty fill: DONE is high at t+1.
- Pass-through latency is exactly 1 cycle.
- The mirror updates on the same edge that registers the forwarded write.
- BUSY falls in the same cycle DONE rises.
- A CPU write in the FIN cycle is dropped.

## Test plan
- **Reset.** Hold RESET=0 mid-fill → all outputs 0 immediately. After release, VGA_WE=0 until the first CPU write.
- **Basic fill.** X0=10, Y0=20, W=2, H=2, COLOUR=0x5A, CMD=0x01 → 16 bus cycles writing pixels (10,20), (11,20), (10,21), (11,21) with data 0x5A; DONE at t+17.
- **Clipping.** X0=158, W=5, Y0=119, H=3 → exactly 2 pixels, (158,119) and (159,119); DONE at t+9.
- **Empty and busy.**
  - W=0, CMD=0x01 → DONE at t+1, no VGA_WE, BUSY stays 0.
  - CPU write to 0xB0 while busy → not forwarded.
- **Abort.** Start 4×1 at (0,0); CMD=0x02 during the first pixel's EMIT_Y → only (0,0) is written; DONE at t+5.
- **Refused start.** CPU writes 0xB0 only, then CMD=0x01 → START_ERR=1, no fill. CPU then writes 0xB1, 0xB2 and CMD=0x01 again → fill runs and START_ERR=0.
